// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the iterative round sequencer:
//   - DATA_W / NUM_ROUNDS constants
//   - FSM state enum {IDLE, RUN, DONE}
//   - RCON round-constant table (rounds 1..10)
//   - GF(2^8) helpers and the S-box, shared by the key step and the round
//     datapath
//   - byte-level round transforms (SubBytes+ShiftRows, MixColumns)
// Byte order throughout: byte 0 = bits [127:120]. Bytes fill the AES state
// column by column, so byte i sits at row i%4, column i/4.
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int DATA_W     = 128;
    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // RCON table, indexed by round number 1..10. Anything else returns 0.
    // Round 0 is never used for a key step.
    function automatic logic [7:0] rcon_for(input logic [3:0] k);
        logic [7:0] r;
        case (k)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed arithmetically: multiplicative inverse as x^254
    // (= x^2 * x^4 * ... * x^128, which maps 0 to 0 as AES requires),
    // followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = gf_mul(x, x);
        inv = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // SubBytes and ShiftRows fused: output byte (row r, col c) takes the
    // substituted input byte from (row r, col (c+r) mod 4).
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(row + 4*c) -: 8] = sbox(s[127 - 8*(row + 4*((c + row) % 4)) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// ---------------------------------------------------------------------------
// aes_key_step
// Combinational AES-128 key schedule step: derives the next round key from
// the previous one.
// Ports:
//   prevKey [127:0] in   previous round key (w0 = bits [127:96])
//   rcon    [7:0]   in   round constant for the key being produced
//   nextKey [127:0] out  next round key
// ---------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] prevKey,
    input  logic [7:0]   rcon,
    output logic [127:0] nextKey
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot_w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    assign w0 = prevKey[127:96];
    assign w1 = prevKey[95:64];
    assign w2 = prevKey[63:32];
    assign w3 = prevKey[31:0];

    // RotWord, then SubWord, then rcon into the leading byte.
    assign rot_w3 = {w3[23:0], w3[31:24]};
    assign temp   = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                     sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])} ^ {rcon, 24'h000000};

    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign nextKey = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_rounds.sv
// ---------------------------------------------------------------------------
// aes_cipher_round / aes_last_round
// Combinational AES round datapaths.
//   aes_cipher_round: SubBytes, ShiftRows, MixColumns, AddRoundKey
//   aes_last_round:   SubBytes, ShiftRows, AddRoundKey (no MixColumns)
// Ports (both modules):
//   state_in  [127:0] in   state entering the round
//   round_key [127:0] in   round key for this round
//   state_out [127:0] out  state leaving the round
// ---------------------------------------------------------------------------
module aes_cipher_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);

    assign state_out = mix_columns(sub_shift(state_in)) ^ round_key;

endmodule

module aes_last_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic [127:0] state_out
);

    assign state_out = sub_shift(state_in) ^ round_key;

endmodule

// File: rtl/aes_round_sequencer.sv
// ---------------------------------------------------------------------------
// aes_round_sequencer
// Iterative AES-128 encryption controller. Accepts one plaintext/key pair,
// applies the initial AddRoundKey, then runs 9 full rounds and the final
// round through one shared round datapath, one round per clock, generating
// round keys on the fly. The ciphertext is held until the consumer takes it.
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high; clears all state
//   inValid    in   plainText/cipherKey valid
//   inReady    out  high in IDLE only
//   plainText  in   [127:0] input block, byte 0 = bits [127:120]
//   cipherKey  in   [127:0] cipher key, same byte order
//   outValid   out  cipherText valid (DONE), held until outReady
//   outReady   in   consumer takes cipherText
//   cipherText out  [127:0] result, zero unless outValid
//   busy       out  high while rounds are in progress (RUN)
//   roundIdx   out  [3:0] round about to be applied, 0 in IDLE/DONE
// ---------------------------------------------------------------------------
module aes_round_sequencer
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] plainText,
    input  logic [DATA_W-1:0] cipherKey,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] cipherText,
    output logic              busy,
    output logic [3:0]        roundIdx
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] block_q, block_d;
    logic [DATA_W-1:0] key_q,   key_d;
    logic [3:0]        round_q, round_d;

    logic [7:0]        rcon_cur;
    logic [DATA_W-1:0] next_key;
    logic [DATA_W-1:0] mid_out;
    logic [DATA_W-1:0] last_out;
    logic              last_round;

    assign last_round = (round_q == 4'(NUM_ROUNDS));
    assign rcon_cur   = rcon_for(round_q);

    aes_key_step u_key_step (
        .prevKey (key_q),
        .rcon    (rcon_cur),
        .nextKey (next_key)
    );

    aes_cipher_round u_cipher_round (
        .state_in  (block_q),
        .round_key (next_key),
        .state_out (mid_out)
    );

    aes_last_round u_last_round (
        .state_in  (block_q),
        .round_key (next_key),
        .state_out (last_out)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        block_d = block_q;
        key_d   = key_q;
        round_d = round_q;

        unique case (state_q)
            IDLE: begin
                if (inValid) begin
                    block_d = plainText ^ cipherKey;
                    key_d   = cipherKey;
                    round_d = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                block_d = last_round ? last_out : mid_out;
                key_d   = next_key;
                if (last_round) begin
                    round_d = 4'd0;
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                if (outReady) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments for all registered state, so every flop
    // samples its _d value from before the edge regardless of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            block_q <= '0;
            key_q   <= '0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            block_q <= block_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    assign inReady    = (state_q == IDLE);
    assign busy       = (state_q == RUN);
    assign outValid   = (state_q == DONE);
    // Intermediate round states never reach the output port.
    assign cipherText = (state_q == DONE) ? block_q : '0;
    assign roundIdx   = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
`timescale 1ns/1ps
module tb_aes_round_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         inValid;
    logic         inReady;
    logic [127:0] plainText;
    logic [127:0] cipherKey;
    logic         outValid;
    logic         outReady;
    logic [127:0] cipherText;
    logic         busy;
    logic [3:0]   roundIdx;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    // Reset view of {inReady, outValid, busy, roundIdx, cipherText}
    localparam logic [134:0] IDLE_VIEW = {1'b1, 1'b0, 1'b0, 4'd0, 128'h0};

    logic [7:0] sbox_t [256];
    logic [7:0] rcon_t [11];

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .inValid    (inValid),
        .inReady    (inReady),
        .plainText  (plainText),
        .cipherKey  (cipherKey),
        .outValid   (outValid),
        .outReady   (outReady),
        .cipherText (cipherText),
        .busy       (busy),
        .roundIdx   (roundIdx)
    );

    // ------------------------------------------------------------------
    // Reference model: textbook AES-128 on a byte array with a fully
    // expanded key schedule (44 words).
    // ------------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box by walking the multiplicative group with generator 3 and its
    // inverse in lockstep; RCON by repeated doubling.
    task automatic build_tables();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        logic [7:0] rc;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
        rcon_t[0] = 8'h00;
        rc = 8'h01;
        for (int j = 1; j <= 10; j++) begin
            rcon_t[j] = rc;
            rc = gmul(rc, 8'h02);
        end
    endtask

    // State after 'rounds' rounds (0 = after the initial AddRoundKey).
    function automatic logic [127:0] model_aes(input logic [127:0] pt, input logic [127:0] key,
                                               input int rounds);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rcon_t[i/4], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= rounds; r++) begin
            for (int i = 0; i < 16; i++) u[i] = sbox_t[s[i]];
            for (int i = 0; i < 16; i++) s[i] = u[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Drivers (called at a falling edge, return at a falling edge)
    // ------------------------------------------------------------------
    task automatic start_job(input logic [127:0] pt, input logic [127:0] key);
        int guard;
        guard = 0;
        while (!inReady && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        plainText = pt;
        cipherKey = key;
        inValid   = 1'b1;
        @(negedge clk);
        inValid   = 1'b0;
    endtask

    // lat counts rising edges after the accept edge.
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!outValid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        inValid = 1'b0;
        outReady = 1'b0;
        plainText = '0;
        cipherKey = '0;
        @(negedge clk);
        checks++;
        if ({inReady, outValid, busy, roundIdx, cipherText} !== IDLE_VIEW) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {inReady, outValid, busy, roundIdx, cipherText}, IDLE_VIEW);
        end
        // inValid while reset is held is not accepted
        inValid = 1'b1;
        plainText = C1_PT;
        cipherKey = C1_KEY;
        @(negedge clk);
        inValid = 1'b0;
        checks++;
        if (busy !== 1'b0 || roundIdx !== 4'd0) begin
            errors++;
            $display("FAIL reset_holds: busy=%b roundIdx=%0d expected busy=0 roundIdx=0", busy, roundIdx);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({inReady, outValid, busy, roundIdx, cipherText} !== IDLE_VIEW) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h",
                     {inReady, outValid, busy, roundIdx, cipherText}, IDLE_VIEW);
        end
    endtask

    task automatic test_fips_c1();
        int lat;
        start_job(C1_PT, C1_KEY);
        checks++;
        if (busy !== 1'b1 || inReady !== 1'b0 || roundIdx !== 4'd1) begin
            errors++;
            $display("FAIL c1_run_entry: busy=%b inReady=%b roundIdx=%0d expected 1 0 1", busy, inReady, roundIdx);
        end
        wait_done(0, lat);
        checks++;
        if (!outValid || lat != 10) begin
            errors++;
            $display("FAIL c1_latency: outValid=%b latency=%0d expected outValid=1 latency=10", outValid, lat);
        end
        checks++;
        if (cipherText !== C1_CT) begin
            errors++;
            $display("FAIL c1_result: got %h expected %h", cipherText, C1_CT);
        end
        checks++;
        if (cipherText !== model_aes(C1_PT, C1_KEY, 10)) begin
            errors++;
            $display("FAIL c1_model: got %h expected %h", cipherText, model_aes(C1_PT, C1_KEY, 10));
        end
        checks++;
        if (busy !== 1'b0 || inReady !== 1'b0 || roundIdx !== 4'd0) begin
            errors++;
            $display("FAIL c1_done_flags: busy=%b inReady=%b roundIdx=%0d expected 0 0 0", busy, inReady, roundIdx);
        end
        consume();
        checks++;
        if ({inReady, outValid, busy, roundIdx, cipherText} !== IDLE_VIEW) begin
            errors++;
            $display("FAIL c1_return_idle: got %h expected %h",
                     {inReady, outValid, busy, roundIdx, cipherText}, IDLE_VIEW);
        end
    endtask

    task automatic test_fips_b();
        int lat;
        logic [127:0] exp1;
        exp1 = model_aes(B_PT, B_KEY, 1);
        start_job(B_PT, B_KEY);
        checks++;
        if (dut.block_q !== model_aes(B_PT, B_KEY, 0)) begin
            errors++;
            $display("FAIL b_initial_ark: got %h expected %h", dut.block_q, model_aes(B_PT, B_KEY, 0));
        end
        @(negedge clk);
        checks++;
        if (dut.block_q !== exp1 || roundIdx !== 4'd2) begin
            errors++;
            $display("FAIL b_after_round1: state=%h roundIdx=%0d expected %h roundIdx=2", dut.block_q, roundIdx, exp1);
        end
        wait_done(1, lat);
        checks++;
        if (!outValid || lat != 10 || cipherText !== B_CT) begin
            errors++;
            $display("FAIL b_result: outValid=%b latency=%0d got %h expected latency=10 %h",
                     outValid, lat, cipherText, B_CT);
        end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        start_job(C1_PT, C1_KEY);
        wait_done(0, lat);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({outValid, inReady, busy, cipherText} !== {1'b1, 1'b0, 1'b0, C1_CT}) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL bp_hold cycle %0d: v=%b rdy=%b busy=%b ct=%h expected 1 0 0 %h",
                             i, outValid, inReady, busy, cipherText, C1_CT);
            end
        end
        consume();
        checks++;
        if ({inReady, outValid, busy, roundIdx, cipherText} !== IDLE_VIEW) begin
            errors++;
            $display("FAIL bp_release: got %h expected %h",
                     {inReady, outValid, busy, roundIdx, cipherText}, IDLE_VIEW);
        end
    endtask

    task automatic test_busy_input();
        int lat;
        start_job(C1_PT, C1_KEY);            // RUN cycle 1
        repeat (2) @(negedge clk);           // RUN cycle 3
        plainText = {$urandom, $urandom, $urandom, $urandom};
        cipherKey = {$urandom, $urandom, $urandom, $urandom};
        inValid = 1'b1;
        checks++;
        if (inReady !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_ready: inReady=%b busy=%b expected 0 1", inReady, busy);
        end
        @(negedge clk);
        inValid = 1'b0;
        repeat (3) @(negedge clk);           // RUN cycle 7
        plainText = {$urandom, $urandom, $urandom, $urandom};
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        wait_done(7, lat);
        checks++;
        if (!outValid || lat != 10 || cipherText !== C1_CT) begin
            errors++;
            $display("FAIL busy_ignored: outValid=%b latency=%0d got %h expected latency=10 %h",
                     outValid, lat, cipherText, C1_CT);
        end
        consume();
    endtask

    task automatic test_reset_mid_run();
        int guard;
        int lat;
        start_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        guard = 0;
        while (roundIdx !== 4'd5 && guard < 15) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (roundIdx !== 4'd5) begin
            errors++;
            $display("FAIL rst_reach_round5: roundIdx=%0d expected 5", roundIdx);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({inReady, outValid, busy, roundIdx, cipherText} !== IDLE_VIEW) begin
            errors++;
            $display("FAIL rst_async: got %h expected %h",
                     {inReady, outValid, busy, roundIdx, cipherText}, IDLE_VIEW);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_job(C1_PT, C1_KEY);
        wait_done(0, lat);
        checks++;
        if (!outValid || lat != 10 || cipherText !== C1_CT) begin
            errors++;
            $display("FAIL rst_rerun: outValid=%b latency=%0d got %h expected latency=10 %h",
                     outValid, lat, cipherText, C1_CT);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [127:0] p1, k1, p2, k2;
        int           acc [$];
        logic [127:0] res [$];
        int           ridx [$];
        int           cyc;
        int           bad;
        p1 = {$urandom, $urandom, $urandom, $urandom};
        k1 = {$urandom, $urandom, $urandom, $urandom};
        p2 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        outReady = 1'b1;
        cyc = 0;
        while (cyc < 80 && res.size() < 2) begin
            if (outValid) res.push_back(cipherText);
            if (busy) ridx.push_back(int'(roundIdx));
            if (acc.size() == 0) begin
                plainText = p1; cipherKey = k1; inValid = 1'b1;
            end else if (acc.size() == 1) begin
                plainText = p2; cipherKey = k2; inValid = 1'b1;
            end else begin
                inValid = 1'b0;
            end
            if (inValid && inReady) acc.push_back(cyc);
            @(negedge clk);
            cyc++;
        end
        inValid = 1'b0;
        outReady = 1'b0;
        checks++;
        if (acc.size() != 2 || res.size() != 2) begin
            errors++;
            $display("FAIL b2b_counts: accepts=%0d results=%0d expected 2 2", acc.size(), res.size());
        end else begin
            checks++;
            if (acc[1] - acc[0] != 12) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d cycles expected 12", acc[1] - acc[0]);
            end
            checks++;
            if (res[0] !== model_aes(p1, k1, 10)) begin
                errors++;
                $display("FAIL b2b_result1: got %h expected %h", res[0], model_aes(p1, k1, 10));
            end
            checks++;
            if (res[1] !== model_aes(p2, k2, 10)) begin
                errors++;
                $display("FAIL b2b_result2: got %h expected %h", res[1], model_aes(p2, k2, 10));
            end
        end
        checks++;
        bad = 0;
        if (ridx.size() != 20) begin
            bad = 1;
        end else begin
            for (int i = 0; i < 20; i++) if (ridx[i] != (i % 10) + 1) bad = 1;
        end
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_round_seq: %0d busy samples, sequence %p expected 1..10 twice", ridx.size(), ridx);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [127:0] pt, key, exp_ct;
        for (int j = 0; j < 6; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            exp_ct = model_aes(pt, key, 10);
            start_job(pt, key);
            wait_done(0, lat);
            checks++;
            if (!outValid || lat != 10 || cipherText !== exp_ct) begin
                errors++;
                $display("FAIL rand_job%0d: outValid=%b latency=%0d got %h expected latency=10 %h",
                         j, outValid, lat, cipherText, exp_ct);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            checks++;
            if (!outValid || cipherText !== exp_ct) begin
                errors++;
                $display("FAIL rand_hold%0d: outValid=%b got %h expected %h", j, outValid, cipherText, exp_ct);
            end
            consume();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        build_tables();
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_backpressure();
        test_busy_input();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
